execute_stage: RTL and testbench

- Pipeline stage directly upstream of the memory-access stage.
- Consumes decoded instruction details plus two register operand values. Produces a registered `data` word and `out_details`.
- For ALU instructions, `data` is the ALU result. For load/store it is the effective address, which memory-access uses as its address and pass-through result.
- Single-cycle ALU ops. Multiply, divide and remainder run on an iterative multi-cycle unit that stalls the upstream stage.

---
 rtl/execute_stage_pkg.sv | 34 +++
 rtl/execute_stage_if.sv | 20 ++
 rtl/execute_stage_muldiv_unit.sv | 98 +++++++++
 rtl/execute_stage.sv | 93 +++++++++
 tb/tb_execute_stage.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared types for the execute stage.
// - Opcodes the stage cares about.
// - ALU function encoding.
// - Decoded instruction record.
// - Multiply/divide iteration count.
package types;

  localparam int XLEN         = 32;
  localparam int MULDIV_STEPS = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL, DIVU, REMU
  } AluFn;

  typedef enum logic {IDLE, BUSY} MdState;

  typedef struct packed {
    logic        is_valid;
    logic [6:0]  op;
    AluFn        alu_fn;
    logic [11:0] offs;
    logic [4:0]  rd;
  } InstructionDetails;

  function automatic logic is_muldiv(AluFn fn);
    return (fn == MUL) || (fn == DIVU) || (fn == REMU);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode -> execute -> memory-access bundle.
// master: upstream/driver side.
// slave:  execute stage side.
// Inputs to execute:  details, rs1_value, rs2_value.
// Outputs of execute: stall_out, out_details, data.
interface execute_stage_if #(parameter int XLEN = 32);
  import types::*;

  InstructionDetails details;
  logic [XLEN-1:0]   rs1_value;
  logic [XLEN-1:0]   rs2_value;
  logic              stall_out;
  InstructionDetails out_details;
  logic [XLEN-1:0]   data;

  modport master (output details, rs1_value, rs2_value,
                  input  stall_out, out_details, data);
  modport slave  (input  details, rs1_value, rs2_value,
                  output stall_out, out_details, data);
endinterface

// File: rtl/execute_stage_muldiv_unit.sv
// Iterative unsigned multiply / divide.
// - One shift-add (MUL) or restoring-subtract (DIVU/REMU) step per clock.
// - Total of STEPS steps.
// Ports:
// - start:  accept op/a/b (honoured in IDLE only).
// - busy:   an operation is in flight.
// - done:   final step happens on the coming edge.
// - result: valid while done. It already includes that final step.
module muldiv_unit
  import types::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  AluFn            op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(STEPS);

  MdState          state, state_n;
  AluFn            op_q;
  logic [CNT_W-1:0] count;

  // acc: product / partial remainder.
  // x:   multiplicand (shifts left) / dividend-then-quotient.
  // y:   multiplier (shifts right) / divisor.
  logic [XLEN-1:0] acc, x, y;
  logic [XLEN-1:0] acc_n, x_n, y_n;
  logic [XLEN:0]   shifted;

  assign busy = (state == BUSY);
  assign done = busy && (count == CNT_W'(STEPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = BUSY;
      BUSY: if (done)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next-step datapath.
  always_comb begin
    acc_n   = acc;
    x_n     = x;
    y_n     = y;
    shifted = {acc, x[XLEN-1]};
    if (op_q == MUL) begin
      acc_n = acc + (y[0] ? x : '0);
      x_n   = {x[XLEN-2:0], 1'b0};
      y_n   = {1'b0, y[XLEN-1:1]};
    end else if (shifted >= {1'b0, y}) begin
      // The difference is below the divisor, so it fits in XLEN bits.
      acc_n = shifted[XLEN-1:0] - y;
      x_n   = {x[XLEN-2:0], 1'b1};
    end else begin
      acc_n = shifted[XLEN-1:0];
      x_n   = {x[XLEN-2:0], 1'b0};
    end
  end

  assign result = (op_q == DIVU) ? x_n : acc_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= ADD;
      acc   <= '0;
      x     <= '0;
      y     <= '0;
      count <= '0;
    end else if (start && !busy) begin
      op_q  <= op;
      acc   <= '0;
      x     <= a;
      y     <= b;
      count <= '0;
    end else if (busy) begin
      acc   <= acc_n;
      x     <= x_n;
      y     <= y_n;
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage, directly upstream of memory access.
// - Single-cycle ALU ops and load/store effective address.
// - MUL/DIVU/REMU run on muldiv_unit. The upstream stage is stalled until
//   the cycle of the final step.
// Ports:
// - clk, rst_async: clock and asynchronous active-high reset.
// - bus.details, bus.rs1_value, bus.rs2_value: decoded instruction and its
//   operands.
// - bus.stall_out: upstream holds its request.
// - bus.out_details, bus.data: registered instruction copy and its result or
//   address.
module execute_stage
  import types::*;
#(
  parameter int XLEN         = 32,
  parameter int MULDIV_STEPS = 32   // iterative unit assumes one bit per step
) (
  input  logic            clk,
  input  logic            rst_async,
  execute_stage_if.slave  bus
);
  InstructionDetails d, held;
  logic [XLEN-1:0]   a, b, alu_res, offs_ext, md_result;
  logic              is_mem, md_req, md_start, md_busy, md_done;

  assign d        = bus.details;
  assign a        = bus.rs1_value;
  assign b        = bus.rs2_value;
  assign offs_ext = {{(XLEN-12){d.offs[11]}}, d.offs};
  assign is_mem   = (d.op == OPC_LOAD) || (d.op == OPC_STORE);
  assign md_req   = d.is_valid && !is_mem && is_muldiv(d.alu_fn);
  assign md_start = md_req && !md_busy;

  // Stall from the cycle a request appears until the final step's cycle.
  // Forced low during reset, because a request may already be present.
  assign bus.stall_out = !rst_async && (md_busy ? !md_done : md_req);

  always_comb begin
    alu_res = '0;
    if (is_mem) begin
      alu_res = a + offs_ext;
    end else begin
      case (d.alu_fn)
        ADD:  alu_res = a + b;
        SUB:  alu_res = a - b;
        AND:  alu_res = a & b;
        OR:   alu_res = a | b;
        XOR:  alu_res = a ^ b;
        SLL:  alu_res = a << b[4:0];
        SRL:  alu_res = a >> b[4:0];
        SRA:  alu_res = $signed(a) >>> b[4:0];
        SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
        default: alu_res = '0;
      endcase
    end
  end

  muldiv_unit #(.XLEN(XLEN), .STEPS(MULDIV_STEPS)) u_muldiv (
    .clk    (clk),
    .rst    (rst_async),
    .start  (md_start),
    .op     (d.alu_fn),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      bus.out_details <= '0;
      bus.data        <= '0;
      held            <= '0;
    end else if (md_busy) begin
      // Input is the held request and is ignored while busy.
      if (md_done) begin
        bus.out_details <= held;
        bus.data        <= md_result;
      end else begin
        bus.out_details.is_valid <= 1'b0;
      end
    end else if (md_start) begin
      held                     <= d;
      bus.out_details.is_valid <= 1'b0;
    end else begin
      bus.out_details <= d;
      if (d.is_valid) bus.data <= alu_res;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_stage_if #(.XLEN(32)) bus ();

  execute_stage #(.XLEN(32), .MULDIV_STEPS(32)) dut (
    .clk       (clk),
    .rst_async (rst),
    .bus       (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic InstructionDetails mk(logic [6:0] op, AluFn fn, logic [11:0] offs);
    InstructionDetails r;
    r.is_valid = 1'b1;
    r.op       = op;
    r.alu_fn   = fn;
    r.offs     = offs;
    r.rd       = 5'($urandom);
    return r;
  endfunction

  // Reference: the architectural meaning of each instruction.
  function automatic logic [31:0] ref_model(InstructionDetails x, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    if (x.op == OPC_LOAD || x.op == OPC_STORE)
      return a + 32'($signed(x.offs));
    case (x.alu_fn)
      ADD:  return a + b;
      SUB:  return a - b;
      AND:  return a & b;
      OR:   return a | b;
      XOR:  return a ^ b;
      SLL:  return a << b[4:0];
      SRL:  return a >> b[4:0];
      SRA:  return 32'($signed(a) >>> b[4:0]);
      SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU: return (a < b) ? 32'd1 : 32'd0;
      MUL:  begin p = 64'(a) * 64'(b); return p[31:0]; end
      DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REMU: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Present one instruction and wait (bounded) for its result.
  task automatic run(string tag, InstructionDetails x, logic [31:0] a, logic [31:0] b);
    int lat = 0, stalls = 0;
    logic md;
    md = x.op != OPC_LOAD && x.op != OPC_STORE &&
         (x.alu_fn == MUL || x.alu_fn == DIVU || x.alu_fn == REMU);
    bus.details = x; bus.rs1_value = a; bus.rs2_value = b;
    #1;
    while (lat < 40) begin
      if (bus.stall_out) stalls++;
      @(posedge clk); #1;
      lat++;
      if (bus.out_details.is_valid) break;
    end
    chk({tag, ".data"}, bus.data, ref_model(x, a, b));
    chk({tag, ".det"}, 32'(bus.out_details), 32'(x));
    chk({tag, ".lat"}, 32'(lat), md ? 32'd33 : 32'd1);
    chk({tag, ".stalls"}, 32'(stalls), md ? 32'd32 : 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    InstructionDetails x;
    logic [31:0] held;

    // A muldiv request is present during reset; stall must still be low.
    bus.details = mk(OPC_OP, DIVU, 12'd0);
    bus.rs1_value = 32'd1000; bus.rs2_value = 32'd3;
    #1;
    chk("rst.stall", 32'(bus.stall_out), 32'd0);
    chk("rst.valid", 32'(bus.out_details.is_valid), 32'd0);
    chk("rst.data", bus.data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("req.stall", 32'(bus.stall_out), 32'd1);

    // Reset in the middle of a divide.
    repeat (10) @(posedge clk);
    #1;
    chk("mid.stall", 32'(bus.stall_out), 32'd1);
    chk("mid.bubble", 32'(bus.out_details.is_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst.stall", 32'(bus.stall_out), 32'd0);
    chk("midrst.valid", 32'(bus.out_details.is_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run("postrst.add", mk(OPC_OP, ADD, 12'd0), 32'd1, 32'd1);

    // Directed boundary cases.
    run("load", mk(OPC_LOAD, ADD, 12'hFFC), 32'h0000_1000, 32'h1234_5678);
    run("store", mk(OPC_STORE, SUB, 12'h7FF), 32'hFFFF_FF00, 32'd0);
    run("add.wrap", mk(OPC_OP, ADD, 12'd0), 32'hFFFF_FFFF, 32'd1);
    run("sra", mk(OPC_OP, SRA, 12'd0), 32'h8000_0000, 32'd31);
    run("slt", mk(OPC_OP, SLT, 12'd0), 32'hFFFF_FFFF, 32'd1);
    run("sltu", mk(OPC_OP, SLTU, 12'd0), 32'hFFFF_FFFF, 32'd1);
    run("mul", mk(OPC_OP, MUL, 12'd0), 32'h0001_0001, 32'h0001_0001);
    run("after.mul", mk(OPC_OP, XOR, 12'd0), 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run("divu", mk(OPC_OP, DIVU, 12'd0), 32'd100, 32'd7);
    run("remu", mk(OPC_OP, REMU, 12'd0), 32'd100, 32'd7);
    run("divu0", mk(OPC_OP, DIVU, 12'd0), 32'd5, 32'd0);
    run("remu0", mk(OPC_OP, REMU, 12'd0), 32'd5, 32'd0);

    // Bubble input: not valid, data held.
    held = bus.data;
    x = mk(OPC_OP, MUL, 12'd0);
    x.is_valid = 1'b0;
    bus.details = x; bus.rs1_value = 32'd9; bus.rs2_value = 32'd9;
    #1;
    chk("inv.stall", 32'(bus.stall_out), 32'd0);
    @(posedge clk); #1;
    chk("inv.valid", 32'(bus.out_details.is_valid), 32'd0);
    chk("inv.data", bus.data, held);

    // Randomized mix against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [6:0]  op;
      logic [31:0] a, b;
      case ($urandom_range(0, 3))
        0:       op = OPC_LOAD;
        1:       op = OPC_STORE;
        default: op = OPC_OP;
      endcase
      x = mk(op, AluFn'($urandom_range(0, 12)), 12'($urandom));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run($sformatf("rnd%0d", i), x, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
